// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and control states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOT = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// low WIDTH bits of the unsigned product, single-cycle done pulse.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            // Always run all WIDTH steps so latency never depends on operands.
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and response.
// Macro ALU_MC_MUL_EN enables the iterative multiplier for op 111.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    input  logic [2:0]       ALU_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             op_err
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_t       state;
    alu_op_t          op_c;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH:0]   sum_c;
    logic [2*WIDTH-1:0] shl_c;
    logic [SHW-1:0]   sh_amt_c;
    logic             c_c;
    logic             v_c;
    logic             err_c;
    logic             is_mul_c;
    logic             mul_start_c;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_prod_c;

    assign op_c        = alu_op_t'(ALU_op);
    assign mul_start_c = (state == IDLE) && in_valid && is_mul_c;

`ifdef ALU_MC_MUL_EN
    assign is_mul_c = (op_c == OP_MUL);

    alu_mul_iter #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_c),
        .a       (val_A),
        .b       (val_B),
        .done    (mul_done_c),
        .product (mul_prod_c)
    );
`else
    assign is_mul_c   = 1'b0;
    assign mul_done_c = mul_start_c;
    assign mul_prod_c = '0;
`endif

    // Single-cycle datapath, evaluated on the live inputs and captured at acceptance.
    always_comb begin
        res_c    = '0;
        sum_c    = '0;
        c_c      = 1'b0;
        v_c      = 1'b0;
        err_c    = 1'b0;
        sh_amt_c = val_B[SHW-1:0];
        shl_c    = {{WIDTH{1'b0}}, val_A} << sh_amt_c;
        case (op_c)
            OP_ADD: begin
                sum_c = {1'b0, val_A} + {1'b0, val_B};
                res_c = sum_c[WIDTH-1:0];
                c_c   = sum_c[WIDTH];
                v_c   = (val_A[MSB] == val_B[MSB]) && (res_c[MSB] != val_A[MSB]);
            end
            OP_SUB: begin
                res_c = val_A - val_B;
                c_c   = (val_A >= val_B);
                v_c   = (val_A[MSB] != val_B[MSB]) && (res_c[MSB] != val_A[MSB]);
            end
            OP_AND: res_c = val_A & val_B;
            OP_NOT: res_c = ~val_B;
            OP_OR:  res_c = val_A | val_B;
            OP_XOR: res_c = val_A ^ val_B;
            OP_SHL: begin
                res_c = shl_c[WIDTH-1:0];
                c_c   = (sh_amt_c != '0) && shl_c[WIDTH];
            end
            OP_MUL: begin
`ifdef ALU_MC_MUL_EN
                err_c = 1'b0;
`else
                err_c = 1'b1;
`endif
            end
            default: err_c = 1'b1;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALU_out   <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_mul_c) begin
                            state <= BUSY;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            ALU_out   <= res_c;
                            Z         <= (res_c == '0);
                            N         <= res_c[MSB];
                            C         <= c_c;
                            V         <= v_c;
                            op_err    <= err_c;
                        end
                    end
                end
                BUSY: begin
                    if (mul_done_c) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        ALU_out   <= mul_prod_c;
                        Z         <= (mul_prod_c == '0);
                        N         <= mul_prod_c[MSB];
                        C         <= 1'b0;
                        V         <= 1'b0;
                        op_err    <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        ALU_out   <= '0;
                        Z         <= 1'b0;
                        N         <= 1'b0;
                        C         <= 1'b0;
                        V         <= 1'b0;
                        op_err    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    ALU_out   <= '0;
                    Z         <= 1'b0;
                    N         <= 1'b0;
                    C         <= 1'b0;
                    V         <= 1'b0;
                    op_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_alu_mc;

    localparam int W = 16;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] out;
        logic z, n, c, v, err;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         in_valid, in_ready;
    logic [W-1:0] alu_out;
    logic         z, n, c, v;
    logic         out_valid, out_ready, op_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .val_A     (a),
        .val_B     (b),
        .ALU_op    (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_out   (alu_out),
        .Z         (z),
        .N         (n),
        .C         (c),
        .V         (v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    // Reference ALU from arithmetic definitions (signed range check for V).
    function automatic res_t ref_alu(logic [W-1:0] ra, logic [W-1:0] rb, logic [2:0] rop);
        res_t   x;
        longint ua, ub, sa, sb, r, sr, sh;
        x  = '0;
        ua = longint'(ra);
        ub = longint'(rb);
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        r  = 0;
        case (rop)
            3'd0: begin
                r = ua + ub; x.c = (r > 65535);
                sr = sa + sb; x.v = (sr > 32767) || (sr < -32768);
            end
            3'd1: begin
                r = ua - ub; x.c = (ua >= ub);
                sr = sa - sb; x.v = (sr > 32767) || (sr < -32768);
            end
            3'd2: r = ua & ub;
            3'd3: r = ~ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: begin
                sh = ub % 16;
                r = ua << sh;
                x.c = (sh != 0) && (((ua >> (16 - sh)) & 1) == 1);
            end
            default: begin
                if (MUL_EN) r = ua * ub;
                else begin r = 0; x.err = 1'b1; end
            end
        endcase
        x.out = r[W-1:0];
        x.z   = (x.out == '0);
        x.n   = x.out[W-1];
        return x;
    endfunction

    // Transaction-level model: ready/valid flags, MUL countdown, held result.
    bit   m_ready, m_valid;
    int   m_cnt;
    res_t m_res, m_pend;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_cnt <= 0; m_res <= '0;
        end else if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            if (MUL_EN && op == 3'd7) begin
                m_cnt  <= W + 1;
                m_pend <= ref_alu(a, b, op);
            end else begin
                m_valid <= 1'b1;
                m_res   <= ref_alu(a, b, op);
            end
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) begin
                m_cnt <= 0; m_valid <= 1'b1; m_res <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0; m_ready <= 1'b1; m_res <= '0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_tests++;
            if (in_ready !== m_ready || out_valid !== m_valid ||
                {alu_out, z, n, c, v, op_err} !== m_res) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got rdy=%b vld=%b out=%h zncv=%b%b%b%b err=%b want rdy=%b vld=%b out=%h zncv=%b%b%b%b err=%b",
                         $time, in_ready, out_valid, alu_out, z, n, c, v, op_err,
                         m_ready, m_valid, m_res.out, m_res.z, m_res.n, m_res.c, m_res.v, m_res.err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top);
        a = ta; b = tb; op = top; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int  lat;
        bit  rdy_seen, vld_seen;
        logic [W-1:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        cyc();
        check_en = 1'b1;
        cyc();
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out", 32'({out_valid, alu_out, z, n, c, v, op_err}), 32'd0);

        // ADD overflow, then back-pressure with a competing request
        issue(16'h7FFF, 16'h0001, 3'd0);
        chk("add_valid_lat1", 32'(out_valid), 32'd1);
        chk("add_out", 32'(alu_out), 32'h8000);
        chk("add_zncv", 32'({z, n, c, v}), 32'b0101);
        held = alu_out;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); op = 3'd5; in_valid = 1'b1;
            cyc();
            chk("bp_stable", 32'({in_ready, out_valid, alu_out, n, v}), 32'({1'b0, 1'b1, held, 1'b1, 1'b1}));
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_release", 32'({in_ready, out_valid, alu_out}), 32'({1'b1, 1'b0, 16'h0000}));
        cyc();
        chk("no_accept_on_leave", 32'(out_valid), 32'd0);

        issue(16'h0005, 16'h0005, 3'd1);
        chk("sub_out", 32'(alu_out), 32'h0000);
        chk("sub_zncv", 32'({z, n, c, v}), 32'b1010);
        drain();

        issue(16'h8001, 16'h0001, 3'd6);
        chk("shl_out", 32'(alu_out), 32'h0002);
        chk("shl_c", 32'({z, n, c, v}), 32'b0010);
        drain();

        // MUL latency / unsupported path
        issue(16'd300, 16'd7, 3'd7);
        lat = 1; rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            cyc();
            lat++;
        end
        if (MUL_EN) begin
            chk("mul_latency", 32'(lat), 32'd17);
            chk("mul_out", 32'({op_err, alu_out}), 32'({1'b0, 16'd2100}));
            chk("mul_ready_low", 32'(rdy_seen), 32'd0);
        end else begin
            chk("mul_dis_latency", 32'(lat), 32'd1);
            chk("mul_dis_out", 32'({op_err, alu_out, z, n, c, v}), 32'({1'b1, 16'h0000, 4'b1000}));
        end
        drain();

        // Reset during the 8th cycle of a MUL abandons it
        issue(16'h1234, 16'h0003, 3'd7);
        for (int i = 0; i < 6; i++) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid_mul", 32'({in_ready, out_valid, alu_out, z, n, c, v, op_err}),
            32'({1'b1, 1'b0, 16'h0000, 5'b00000}));
        vld_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            vld_seen |= out_valid;
        end
        chk("no_stale_result", 32'(vld_seen), 32'd0);

        // Reset wins over a coincident accept
        a = 16'h0001; b = 16'h0001; op = 3'd0; in_valid = 1'b1; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("rst_vs_accept", 32'({in_ready, out_valid}), 32'b10);

        // Randomized traffic; the per-cycle compare does the checking
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 6);
            a         = rnd_operand();
            b         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 17)) : rnd_operand();
            op        = 3'($urandom_range(0, 7));
            cyc();
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
